// File: rtl/decode_execute_stage.sv
// Decode, operand read, execute and EXE/MEM pipeline register of the MyProc2 pipeline.
// Operands come straight from the register file; hazards are handled only by stalling on busy flags.
module decode_execute_stage #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-3:0]        PC_in,
    input  logic [WIDTH-1:0]        IR_in,
    output logic [REG_ADDR_LEN-1:0] Rd1_addr,
    output logic                    Rd1_en,
    input  logic [WIDTH-1:0]        Rd1_data,
    input  logic                    Rd1_st,
    output logic [REG_ADDR_LEN-1:0] Rd2_addr,
    output logic                    Rd2_en,
    input  logic [WIDTH-1:0]        Rd2_data,
    input  logic                    Rd2_st,
    output logic                    stall,
    output logic [WIDTH-3:0]        PC_out,
    output logic [WIDTH-1:0]        IR_out,
    output logic [WIDTH-1:0]        Z_out,
    output logic [WIDTH-1:0]        Addr_out
);

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_XOR  = 6'h05,
        OP_SLL  = 6'h06,
        OP_SRL  = 6'h07,
        OP_ADDI = 6'h08,
        OP_LD   = 6'h09,
        OP_ST   = 6'h0A,
        OP_BEQ  = 6'h0B,
        OP_HLT  = 6'h3F
    } opcode_e;

    logic [5:0]              w_op;
    logic [REG_ADDR_LEN-1:0] w_rd;
    logic [REG_ADDR_LEN-1:0] w_rs1;
    logic [REG_ADDR_LEN-1:0] w_rs2;
    logic [WIDTH-1:0]        w_imm;
    logic                    w_is_rr;
    logic [WIDTH-1:0]        w_x;
    logic [WIDTH-1:0]        w_y;
    logic [WIDTH-3:0]        w_br_target;
    logic [WIDTH-1:0]        w_z;
    logic [WIDTH-1:0]        w_addr;

    assign w_op   = IR_in[31:26];
    assign w_rd   = IR_in[25:21];
    assign w_rs1  = IR_in[20:16];
    assign w_rs2  = IR_in[15:11];
    assign w_imm  = {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]};

    // Register-register ops (01-07) take Y from port 2; everything else uses the immediate.
    assign w_is_rr = (w_op >= 6'h01) && (w_op <= 6'h07);
    assign w_x     = Rd1_data;
    assign w_y     = w_is_rr ? Rd2_data : w_imm;

    // Branch target lives in the word-addressed PC space, so it wraps at PC width.
    assign w_br_target = PC_in + (WIDTH-2)'(1) + w_imm[WIDTH-3:0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        Rd1_en   = 1'b0;
        Rd1_addr = '0;
        Rd2_en   = 1'b0;
        Rd2_addr = '0;
        w_z      = '0;
        w_addr   = '0;
        case (opcode_e'(w_op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                Rd1_en   = 1'b1;
                Rd1_addr = w_rs1;
                Rd2_en   = 1'b1;
                Rd2_addr = w_rs2;
                case (opcode_e'(w_op))
                    OP_ADD:  w_z = w_x + w_y;
                    OP_SUB:  w_z = w_x - w_y;
                    OP_AND:  w_z = w_x & w_y;
                    OP_OR:   w_z = w_x | w_y;
                    OP_XOR:  w_z = w_x ^ w_y;
                    OP_SLL:  w_z = w_x << w_y[4:0];
                    default: w_z = w_x >> w_y[4:0];
                endcase
            end
            OP_ADDI: begin
                Rd1_en   = 1'b1;
                Rd1_addr = w_rs1;
                w_z      = w_x + w_y;
            end
            OP_LD: begin
                Rd1_en   = 1'b1;
                Rd1_addr = w_rs1;
                w_addr   = w_x + w_y;
            end
            OP_ST: begin
                Rd1_en   = 1'b1;
                Rd1_addr = w_rs1;
                Rd2_en   = 1'b1;
                Rd2_addr = w_rd;
                w_addr   = w_x + w_y;
                w_z      = Rd2_data;
            end
            OP_BEQ: begin
                Rd1_en   = 1'b1;
                Rd1_addr = w_rs1;
                Rd2_en   = 1'b1;
                Rd2_addr = w_rd;
                w_z      = {{(WIDTH-1){1'b0}}, (Rd1_data == Rd2_data)};
                w_addr   = {2'b00, w_br_target};
            end
            default: ;
        endcase
    end

    assign stall = (Rd1_en & Rd1_st) | (Rd2_en & Rd2_st);

    always_ff @(posedge clk) begin
        // NOTE: pipeline state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            PC_out   <= '0;
            IR_out   <= '0;
            Z_out    <= '0;
            Addr_out <= '0;
        end else if (stall) begin
            PC_out   <= '0;
            IR_out   <= '0;
            Z_out    <= '0;
            Addr_out <= '0;
        end else begin
            PC_out   <= PC_in;
            IR_out   <= IR_in;
            Z_out    <= w_z;
            Addr_out <= w_addr;
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: a driver pushes hand-computed EXE/MEM contents into a
// queue, and a monitor pops and compares them one clock later.
module tb_decode_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] PC_in;
    logic [31:0] IR_in;
    logic [4:0]  Rd1_addr;
    logic        Rd1_en;
    logic [31:0] Rd1_data;
    logic        Rd1_st;
    logic [4:0]  Rd2_addr;
    logic        Rd2_en;
    logic [31:0] Rd2_data;
    logic        Rd2_st;
    logic        stall;
    logic [29:0] PC_out;
    logic [31:0] IR_out;
    logic [31:0] Z_out;
    logic [31:0] Addr_out;

    decode_execute_stage #(.WIDTH(32), .REG_ADDR_LEN(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .PC_in    (PC_in),
        .IR_in    (IR_in),
        .Rd1_addr (Rd1_addr),
        .Rd1_en   (Rd1_en),
        .Rd1_data (Rd1_data),
        .Rd1_st   (Rd1_st),
        .Rd2_addr (Rd2_addr),
        .Rd2_en   (Rd2_en),
        .Rd2_data (Rd2_data),
        .Rd2_st   (Rd2_st),
        .stall    (stall),
        .PC_out   (PC_out),
        .IR_out   (IR_out),
        .Z_out    (Z_out),
        .Addr_out (Addr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [29:0] pc;
        logic [31:0] ir;
        logic [31:0] z;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drive_done = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] low);
        return {op, rd, rs1, low};
    endfunction

    function automatic logic [15:0] rr(input logic [4:0] rs2);
        return {rs2, 11'd0};
    endfunction

    // One cycle of stimulus: apply inputs at negedge, check the decode outputs, queue the
    // expected EXE/MEM register contents for the next rising edge.
    task automatic apply(input string name, input logic r, input logic [29:0] pc, input logic [31:0] ir,
                         input logic [31:0] d1, input logic [31:0] d2, input logic s1, input logic s2,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                         input logic est, input logic [31:0] ez, input logic [31:0] ea);
        exp_t e;
        @(negedge clk);
        rst      = r;
        PC_in    = pc;
        IR_in    = ir;
        Rd1_data = d1;
        Rd2_data = d2;
        Rd1_st   = s1;
        Rd2_st   = s2;
        #1;
        check({name, ".stall"},    64'(stall),    64'(est));
        check({name, ".rd1_en"},   64'(Rd1_en),   64'(e1));
        check({name, ".rd1_addr"}, 64'(Rd1_addr), 64'(a1));
        check({name, ".rd2_en"},   64'(Rd2_en),   64'(e2));
        check({name, ".rd2_addr"}, 64'(Rd2_addr), 64'(a2));
        e.name = name;
        if (r || est) begin
            e.pc = '0; e.ir = '0; e.z = '0; e.addr = '0;
        end else begin
            e.pc = pc; e.ir = ir; e.z = ez; e.addr = ea;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: the stage presents a new EXE/MEM word after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc_out"},   64'(PC_out),   64'(e.pc));
                check({e.name, ".ir_out"},   64'(IR_out),   64'(e.ir));
                check({e.name, ".z_out"},    64'(Z_out),    64'(e.z));
                check({e.name, ".addr_out"}, 64'(Addr_out), 64'(e.addr));
            end
        end
    end

    initial begin
        logic [31:0] add_ir;
        logic [31:0] beq_ir;
        add_ir = enc(6'h01, 5'd3, 5'd1, rr(5'd2));
        beq_ir = enc(6'h0B, 5'd7, 5'd8, 16'hFFFE);
        rst = 1'b1; PC_in = '0; IR_in = '0; Rd1_data = '0; Rd2_data = '0; Rd1_st = 1'b0; Rd2_st = 1'b0;

        //     name        rst pc           ir                                  d1            d2            s1 s2 e1 a1    e2 a2    st  z             addr
        apply("reset0",    1, 30'd10,       add_ir,                             32'd5,        32'd7,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd0,        32'd0);
        apply("reset1",    1, 30'd10,       add_ir,                             32'd5,        32'd7,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd0,        32'd0);
        apply("add",       0, 30'd10,       add_ir,                             32'd5,        32'd7,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd12,       32'd0);
        apply("sub_wrap",  0, 30'd11,       enc(6'h02, 5'd4, 5'd2, rr(5'd3)),   32'd0,        32'd1,        0, 0, 1, 5'd2, 1, 5'd3, 0, 32'hFFFFFFFF, 32'd0);
        apply("sll",       0, 30'd12,       enc(6'h06, 5'd5, 5'd9, rr(5'd10)),  32'd1,        32'd31,       0, 0, 1, 5'd9, 1, 5'd10,0, 32'h80000000, 32'd0);
        apply("srl",       0, 30'd13,       enc(6'h07, 5'd5, 5'd9, rr(5'd10)),  32'h80000000, 32'h24,       0, 0, 1, 5'd9, 1, 5'd10,0, 32'h08000000, 32'd0);
        apply("xor",       0, 30'd14,       enc(6'h05, 5'd6, 5'd11,rr(5'd12)),  32'hF0F0FFFF, 32'h0FF0000F, 0, 0, 1, 5'd11,1, 5'd12,0, 32'hFF00FFF0, 32'd0);
        apply("addi",      0, 30'd15,       enc(6'h08, 5'd2, 5'd4, 16'hFFFF),   32'd10,       32'h12345678, 0, 0, 1, 5'd4, 0, 5'd0, 0, 32'd9,        32'd0);
        apply("ld",        0, 30'd16,       enc(6'h09, 5'd2, 5'd4, 16'h0010),   32'h200,      32'h55,       0, 0, 1, 5'd4, 0, 5'd0, 0, 32'd0,        32'h210);
        apply("st",        0, 30'd17,       enc(6'h0A, 5'd6, 5'd5, 16'h0004),   32'd100,      32'hDEAD,     0, 0, 1, 5'd5, 1, 5'd6, 0, 32'hDEAD,     32'd104);
        apply("beq_eq",    0, 30'd20,       beq_ir,                             32'd55,       32'd55,       0, 0, 1, 5'd8, 1, 5'd7, 0, 32'd1,        32'd19);
        apply("beq_ne",    0, 30'd20,       beq_ir,                             32'd55,       32'd56,       0, 0, 1, 5'd8, 1, 5'd7, 0, 32'd0,        32'd19);
        apply("beq_wrap",  0, 30'h3FFFFFFF, enc(6'h0B, 5'd1, 5'd2, 16'h0000),   32'd3,        32'd3,        0, 0, 1, 5'd2, 1, 5'd1, 0, 32'd1,        32'd0);
        apply("hazard",    0, 30'd30,       add_ir,                             32'd5,        32'd7,        1, 0, 1, 5'd1, 1, 5'd2, 1, 32'd0,        32'd0);
        apply("release",   0, 30'd30,       add_ir,                             32'd5,        32'd7,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd12,       32'd0);
        apply("st_haz2",   0, 30'd31,       enc(6'h0A, 5'd6, 5'd5, 16'h0004),   32'd100,      32'hDEAD,     0, 1, 1, 5'd5, 1, 5'd6, 1, 32'd0,        32'd0);
        apply("nop_busy",  0, 30'd32,       enc(6'h00, 5'd1, 5'd2, 16'h1800),   32'd5,        32'd7,        1, 1, 0, 5'd0, 0, 5'd0, 0, 32'd0,        32'd0);
        apply("unknown2a", 0, 30'd33,       enc(6'h2A, 5'd1, 5'd2, rr(5'd3)),   32'd5,        32'd7,        1, 1, 0, 5'd0, 0, 5'd0, 0, 32'd0,        32'd0);
        apply("hlt",       0, 30'd34,       enc(6'h3F, 5'd0, 5'd0, 16'h0000),   32'd5,        32'd7,        0, 0, 0, 5'd0, 0, 5'd0, 0, 32'd0,        32'd0);
        apply("add2",      0, 30'd35,       add_ir,                             32'd40,       32'd2,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd42,       32'd0);
        apply("mid_reset", 1, 30'd36,       add_ir,                             32'd40,       32'd2,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd0,        32'd0);
        apply("post_rst",  0, 30'd37,       add_ir,                             32'd1,        32'd1,        0, 0, 1, 5'd1, 1, 5'd2, 0, 32'd2,        32'd0);
        drive_done = 1'b1;
    end

    initial begin
        wait (drive_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain.queue_left", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

endmodule
